pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register for the 5-stage core, the generalised successor of the fixed MEM/WB latch. It carries an arbitrary-width payload between two stages with a valid/ready handshake. A 2-entry skid buffer registers `in_ready_o` while sustaining one transfer per cycle. System hold and synchronous flush are first-class inputs, and one instance per stage boundary (IF/ID … MEM/WB) replaces the per-stage latches.

---
 rtl/pipe_stage_skid_pkg.sv | 17 +
 rtl/pipe_stage_skid.sv | 132 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid_pkg
// Shared definitions for the pipeline stage register with skid buffer.
//   pipe_state_e : FSM states; the encoding equals the held-entry count.
//   ZERO_WORD    : 32-bit data reset constant.
// -----------------------------------------------------------------------------
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_BUSY  = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Pipeline stage register with a 2-entry skid buffer. It moves an opaque
// payload between two stages over valid/ready at one beat per cycle, with a
// registered ready, a system hold and a synchronous flush.
//
// Parameters
//   DATA_W    : payload width, 1..512
//   FLUSH_CLR : 1 = flush also zeroes both data registers
// Ports
//   clk_100MHz  in  : clock, rising edge
//   arst_n      in  : asynchronous active-low reset
//   in_valid_i  in  : upstream payload valid
//   in_ready_o  out : stage can accept (registered, gated by hold_i)
//   in_data_i   in  : upstream payload
//   out_valid_o out : payload valid downstream (registered, gated by hold_i)
//   out_ready_i in  : downstream accepts
//   out_data_o  out : payload downstream (registered)
//   hold_i      in  : system pause, no transfer on either side
//   flush_i     in  : synchronous kill of all held entries
//   occupancy_o out : held entries, 0..2
// -----------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit FLUSH_CLR = 1'b1
) (
  input  logic              clk_100MHz,
  input  logic              arst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [1:0]        occupancy_o
);

  // The 32-bit core word uses the shared zero constant; other widths replicate.
  localparam logic [DATA_W-1:0] DATA_RST =
    (DATA_W == 32) ? DATA_W'(ZERO_WORD) : {DATA_W{1'b0}};

  pipe_state_e       state_q, state_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] main_q,  main_d;
  logic [DATA_W-1:0] skid_q,  skid_d;

  logic main_v;
  logic in_fire;
  logic out_fire;

  // Only hold_i reaches the handshake outputs combinationally; ready is never
  // derived from out_ready_i, which is what the skid entry buys us.
  assign main_v      = (state_q != PIPE_EMPTY);
  assign in_ready_o  = ready_q & ~hold_i;
  assign out_valid_o = main_v  & ~hold_i;
  assign in_fire     = in_valid_i  & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  assign out_data_o  = main_q;
  assign occupancy_o = state_q;

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    state_d = state_q;
    ready_d = ready_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush_i) begin
      // Flush wins over any same-cycle fire: nothing captured, nothing consumed.
      state_d = PIPE_EMPTY;
      ready_d = 1'b1;
      if (FLUSH_CLR) begin
        main_d = DATA_RST;
        skid_d = DATA_RST;
      end
    end else if (!hold_i) begin
      unique case (state_q)
        PIPE_EMPTY: begin
          if (in_fire) begin
            state_d = PIPE_BUSY;
            main_d  = in_data_i;
          end
        end
        PIPE_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            state_d = PIPE_FULL;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = PIPE_EMPTY;
          end
        end
        PIPE_FULL: begin
          // ready_q is low here, so only the drain can happen.
          if (out_fire) begin
            state_d = PIPE_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = PIPE_EMPTY;
      endcase
      ready_d = (state_d != PIPE_FULL);
    end
    // hold_i with no flush: everything keeps its default (frozen).
  end

  // NOTE: state uses non-blocking assignments so all flops sample the same
  // pre-edge values regardless of process ordering.
  // NOTE: the data registers are reset too (not left as don't-care), because
  // out_data_o is observable and must read zero out of reset.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= PIPE_EMPTY;
      ready_q <= 1'b1;
      main_q  <= DATA_RST;
      skid_q  <= DATA_RST;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
// Directed bench for pipe_stage_skid. Inputs change 1 ns after the rising edge;
// a negedge monitor scores every accepted beat against a FIFO of payloads and
// every delivered beat against its head. Directed checks read state 1 ns after
// the edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;

  logic              clk_100MHz;
  logic              arst_n;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic              hold_i;
  logic              flush_i;
  logic [1:0]        occupancy_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] sb[$];

  pipe_stage_skid #(.DATA_W(DATA_W), .FLUSH_CLR(1'b1)) dut (
    .clk_100MHz (clk_100MHz),
    .arst_n     (arst_n),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .hold_i     (hold_i),
    .flush_i    (flush_i),
    .occupancy_o(occupancy_o)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  // Inputs are stable from 1 ns after an edge until the next edge, so what the
  // monitor sees at the negedge is exactly what the coming edge will act on.
  always @(negedge clk_100MHz) begin
    if (!arst_n || flush_i) begin
      sb.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", out_data_o, {DATA_W{1'bx}});
        end else begin
          check("sb_out_data", out_data_o, sb.pop_front());
        end
      end
      if (in_valid_i && in_ready_o) sb.push_back(in_data_i);
    end
  end

  initial begin
    arst_n      = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    hold_i      = 1'b0;
    flush_i     = 1'b0;

    // ---- reset / idle
    repeat (3) tick();
    arst_n = 1'b1;
    tick();
    check("rst_occ",      occupancy_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_data", out_data_o,  0);
    check("rst_in_ready", in_ready_o,  1);

    // ---- streaming, no bubbles
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_data_i   = 32'h11; tick();
    check("str_occ_1", occupancy_o, 1);
    check("str_data_1", out_data_o, 32'h11);
    check("str_vld_1", out_valid_o, 1);
    in_data_i   = 32'h22; tick();
    check("str_occ_2", occupancy_o, 1);
    check("str_data_2", out_data_o, 32'h22);
    check("str_rdy_2", in_ready_o, 1);
    in_data_i   = 32'h33; tick();
    check("str_occ_3", occupancy_o, 1);
    check("str_data_3", out_data_o, 32'h33);
    in_valid_i  = 1'b0; tick();
    check("str_drained", occupancy_o, 0);
    check("str_sb_empty", sb.size(), 0);

    // ---- backpressure
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 32'hA1; tick();
    check("bp_occ_1", occupancy_o, 1);
    in_data_i   = 32'hA2; tick();
    check("bp_occ_2", occupancy_o, 2);
    check("bp_main", out_data_o, 32'hA1);
    check("bp_skid", dut.skid_q, 32'hA2);
    check("bp_rdy_low", in_ready_o, 0);
    in_data_i   = 32'hA3; tick();
    check("bp_stall_occ", occupancy_o, 2);
    check("bp_stall_data", out_data_o, 32'hA1);
    out_ready_i = 1'b1; tick();
    check("bp_drain_occ", occupancy_o, 1);
    check("bp_drain_data", out_data_o, 32'hA2);
    check("bp_drain_rdy", in_ready_o, 1);
    tick();
    check("bp_a3_data", out_data_o, 32'hA3);
    check("bp_a3_occ", occupancy_o, 1);
    in_valid_i  = 1'b0; tick();
    check("bp_done_occ", occupancy_o, 0);
    check("bp_sb_empty", sb.size(), 0);

    // ---- hold while FULL
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 32'hB1; tick();
    in_data_i   = 32'hB2; tick();
    in_valid_i  = 1'b0;
    check("hold_pre_occ", occupancy_o, 2);
    hold_i      = 1'b1;
    out_ready_i = 1'b1;
    #1;
    check("hold_vld_comb", out_valid_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_vld", out_valid_o, 0);
      check("hold_rdy", in_ready_o, 0);
      check("hold_occ", occupancy_o, 2);
    end
    hold_i = 1'b0;
    tick();
    check("hold_rel_occ", occupancy_o, 1);
    check("hold_rel_data", out_data_o, 32'hB2);
    tick();
    check("hold_done_occ", occupancy_o, 0);
    check("hold_sb_empty", sb.size(), 0);

    // ---- flush with simultaneous traffic
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 32'hC1; tick();
    check("fl_pre_occ", occupancy_o, 1);
    check("fl_pre_data", out_data_o, 32'hC1);
    flush_i     = 1'b1;
    in_data_i   = 32'hC2;
    out_ready_i = 1'b1;
    tick();
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    check("fl_occ", occupancy_o, 0);
    check("fl_vld", out_valid_o, 0);
    check("fl_data", out_data_o, 0);
    check("fl_rdy", in_ready_o, 1);
    tick();
    check("fl_idle_occ", occupancy_o, 0);

    // ---- mid-operation asynchronous reset
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 32'hD1; tick();
    in_data_i   = 32'hD2; tick();
    in_valid_i  = 1'b0;
    check("mr_pre_occ", occupancy_o, 2);
    #1 arst_n = 1'b0;
    #1;
    check("mr_occ", occupancy_o, 0);
    check("mr_vld", out_valid_o, 0);
    check("mr_data", out_data_o, 0);
    check("mr_rdy", in_ready_o, 1);
    check("mr_skid", dut.skid_q, 0);
    arst_n = 1'b1;
    sb.delete();
    tick();
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_data_i   = 32'hD3; tick();
    in_valid_i  = 1'b0;
    check("mr_d3_occ", occupancy_o, 1);
    check("mr_d3_vld", out_valid_o, 1);
    check("mr_d3_data", out_data_o, 32'hD3);
    tick();
    check("mr_done_occ", occupancy_o, 0);
    check("mr_sb_empty", sb.size(), 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
